// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the fifo write-port arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fifo_arb_pkg;

   // Arbiter state: IDLE picks the next owner, GRANT forwards the owner's stream.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Default build point for the arbiter.
   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_MAX_BURST  = 4;

   // Width of an owner index; a single-requester build still needs one bit.
   function automatic int id_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   // Burst counter width; holds 0 .. MAX_BURST-1 with headroom.
   function automatic int cnt_width(input int max_burst);
      return $clog2(max_burst) + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority pick: first set bit of req scanning last+1, last+2, ... mod N.
// Latency: purely combinational.
// Backpressure: none; caller decides when the pick is consumed.
// Ports: req (request vector), last (previous winner, lowest priority),
//        pick_valid (any request set), pick_id (winning index).
module rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] last,
   output logic            pick_valid,
   output logic [ID_W-1:0] pick_id
);

   logic [ID_W-1:0] cand;

   always_comb begin
      pick_valid = 1'b0;
      pick_id    = '0;
      cand       = '0;
      // Offset 1 first so 'last' itself is only reached after everyone else.
      for (int i = 1; i <= N; i++) begin
         cand = ID_W'((int'(last) + i) % N);
         if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick_id    = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ valid/ready producers.
// Latency: 1 cycle valid-to-grant; one IDLE bubble after every release.
// Backpressure: fifo_wr_ready low holds grant and burst count, all req_ready low.
// Ports: clk/reset (sync, active-high); req_valid/req_data/req_ready per producer;
//        fifo_wr_en/fifo_wr_data/fifo_wr_ready to the fifo; grant_valid/grant_id status.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_BURST  = DEF_MAX_BURST,
   parameter int ID_W       = id_width(NUM_REQ),
   parameter int CNT_W      = cnt_width(MAX_BURST)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   input  logic                          fifo_wr_ready,
   output logic                          grant_valid,
   output logic [ID_W-1:0]               grant_id
);

   arb_state_t       state_q, state_d;
   logic [ID_W-1:0]  owner_q, owner_d;
   logic [ID_W-1:0]  last_owner_q, last_owner_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

   logic             pick_valid;
   logic [ID_W-1:0]  pick_id;

   rr_pick #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_rr_pick (
      .req        (req_valid),
      .last       (last_owner_q),
      .pick_valid (pick_valid),
      .pick_id    (pick_id)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      grant_valid  = 1'b0;
      grant_id     = '0;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d     = pick_id;
               burst_cnt_d = '0;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            grant_valid        = 1'b1;
            grant_id           = owner_q;
            req_ready[owner_q] = fifo_wr_ready;
            fifo_wr_en         = req_valid[owner_q] & fifo_wr_ready;
            fifo_wr_data       = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];

            // An idle owner gives up the port at once; a full fifo alone never
            // releases it, so a stalled burst resumes where it left off.
            if (!req_valid[owner_q] ||
                (fifo_wr_en && burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
               state_d      = IDLE;
               last_owner_d = owner_q;
               burst_cnt_d  = '0;
            end else if (fifo_wr_en) begin
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         // Highest index as 'last' gives producer 0 first priority out of reset.
         last_owner_q <= ID_W'(NUM_REQ - 1);
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

endmodule
